// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared encodings for the iterative RV32M multiply/divide unit:
//   operation codes (3 bits) and FSM state codes (2 bits), plus small
//   decode helpers for the operation encoding.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MULDIV_OP_MUL    = 3'd0,
        MULDIV_OP_MULH   = 3'd1,
        MULDIV_OP_MULHSU = 3'd2,
        MULDIV_OP_MULHU  = 3'd3,
        MULDIV_OP_DIV    = 3'd4,
        MULDIV_OP_DIVU   = 3'd5,
        MULDIV_OP_REM    = 3'd6,
        MULDIV_OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MULDIV_STATE_IDLE = 2'd0,
        MULDIV_STATE_CALC = 2'd1,
        MULDIV_STATE_DONE = 2'd2
    } muldiv_state_e;

    // rs1 is interpreted as signed
    function automatic logic op_signed_a(input muldiv_op_e op);
        return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
               (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic op_signed_b(input muldiv_op_e op);
        return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) ||
               (op == MULDIV_OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// mul_div_step
//   One combinational radix-2 iteration on a 2*XLEN accumulator.
//   Multiply : acc = {product_hi, multiplier}; shift-add, LSB first.
//   Divide   : acc = {remainder, dividend/quotient}; restoring step, MSB first.
// Ports:
//   acc_in   accumulator before the step
//   operand  multiplicand / divisor (magnitude)
//   is_div   1 = divide step, 0 = multiply step
//   acc_out  accumulator after the step
module mul_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
        shifted = acc_in[2*XLEN-1:XLEN-1];
        // diff[XLEN] is the borrow: set when the shifted remainder < divisor
        diff    = shifted - {1'b0, operand};
        acc_out = '0;
        if (is_div) begin
            if (!diff[XLEN])
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            else
                acc_out = {shifted[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end else begin
            if (acc_in[0])
                acc_out = {sum, acc_in[XLEN-1:1]};
            else
                acc_out = {1'b0, acc_in[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit for the execute stage. Accepts one
//   operation on valid_In & ready_Out, runs XLEN/STEPS iteration cycles plus
//   one sign-correction cycle, then holds the result until resultReady_In.
//   flush_In aborts in any state without delivering a result.
// Ports:
//   clk, rst (async active-low)
//   op_In, operandA_In, operandB_In, valid_In, ready_Out   request side
//   flush_In                                                pipeline abort
//   result_Out, resultValid_Out, resultReady_In             result side
//   busy_Out                                                exec lock
// Build option:
//   MULDIV_EARLY_OUT_EN  divide-by-zero, signed overflow and MUL-family ops
//                        with a zero operand complete at the accept edge.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op_In,
    input  logic [XLEN-1:0] operandA_In,
    input  logic [XLEN-1:0] operandB_In,
    input  logic            valid_In,
    output logic            ready_Out,
    input  logic            flush_In,
    output logic [XLEN-1:0] result_Out,
    output logic            resultValid_Out,
    input  logic            resultReady_In,
    output logic            busy_Out
);

    localparam int unsigned ITERS = XLEN / STEPS;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state, state_next;
    muldiv_op_e        op_in, op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [CNT_W-1:0]  count_q;
    logic              sign_a_q, sign_b_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res_q;

    logic              accept, early;
    logic              sign_a_in, sign_b_in;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              special_in;
    logic [XLEN-1:0]   special_res_in;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

    logic [2*XLEN-1:0] chain [STEPS+1];

    assign op_in           = muldiv_op_e'(op_In);
    assign ready_Out       = (state == MULDIV_STATE_IDLE);
    assign busy_Out        = (state != MULDIV_STATE_IDLE);
    assign resultValid_Out = (state == MULDIV_STATE_DONE);
    assign accept          = valid_In & ready_Out & ~flush_In;

    // Request decode: magnitudes and RISC-V special cases
    always_comb begin
        sign_a_in      = op_signed_a(op_in) & operandA_In[XLEN-1];
        sign_b_in      = op_signed_b(op_in) & operandB_In[XLEN-1];
        abs_a          = sign_a_in ? -operandA_In : operandA_In;
        abs_b          = sign_b_in ? -operandB_In : operandB_In;
        special_in     = 1'b0;
        special_res_in = '0;
        if (op_In[2]) begin
            if (operandB_In == '0) begin
                special_in     = 1'b1;
                special_res_in = op_In[1] ? operandA_In : '1;
            end else if ((op_in == MULDIV_OP_DIV || op_in == MULDIV_OP_REM) &&
                         operandA_In == MIN_NEG && operandB_In == '1) begin
                special_in     = 1'b1;
                special_res_in = op_In[1] ? '0 : MIN_NEG;
            end
        end else if (operandA_In == '0 || operandB_In == '0) begin
            special_in     = 1'b1;
            special_res_in = '0;
        end
`ifdef MULDIV_EARLY_OUT_EN
        early = special_in;
`else
        early = 1'b0;
`endif
    end

    // STEPS radix-2 iterations per clock
    assign chain[0] = acc_q;
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        mul_div_step #(.XLEN(XLEN)) u_step (
            .acc_in  (chain[g]),
            .operand (opb_q),
            .is_div  (op_q[2]),
            .acc_out (chain[g+1])
        );
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        final_res = '0;
        case (op_q)
            MULDIV_OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            MULDIV_OP_MULH, MULDIV_OP_MULHSU,
            MULDIV_OP_MULHU:                     final_res = prod_fix[2*XLEN-1:XLEN];
            MULDIV_OP_DIV, MULDIV_OP_DIVU:       final_res = quot_fix;
            MULDIV_OP_REM, MULDIV_OP_REMU:       final_res = rem_fix;
            default:                             final_res = '0;
        endcase
        if (special_q)
            final_res = special_res_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= MULDIV_STATE_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MULDIV_STATE_IDLE:
                if (accept)
                    state_next = early ? MULDIV_STATE_DONE : MULDIV_STATE_CALC;
            MULDIV_STATE_CALC:
                if (count_q == '0)
                    state_next = MULDIV_STATE_DONE;
            MULDIV_STATE_DONE:
                if (resultReady_In)
                    state_next = MULDIV_STATE_IDLE;
            default:
                state_next = MULDIV_STATE_IDLE;
        endcase
        if (flush_In)
            state_next = MULDIV_STATE_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q          <= MULDIV_OP_MUL;
            acc_q         <= '0;
            opb_q         <= '0;
            count_q       <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_Out    <= '0;
        end else if (accept) begin
            op_q          <= op_in;
            acc_q         <= {{XLEN{1'b0}}, abs_a};
            opb_q         <= abs_b;
            count_q       <= CNT_W'(ITERS);
            sign_a_q      <= sign_a_in;
            sign_b_q      <= sign_b_in;
            special_q     <= special_in;
            special_res_q <= special_res_in;
            if (early)
                result_Out <= special_res_in;
        end else if (state == MULDIV_STATE_CALC && !flush_In) begin
            // Counter exhausted: one extra cycle applies sign correction
            if (count_q != '0) begin
                acc_q   <= chain[STEPS];
                count_q <= count_q - CNT_W'(1);
            end else begin
                result_Out <= final_res;
            end
        end
    end

endmodule
